// File: rtl/otter_mem_responder_if.sv
// Request/response bundle between the OTTER control unit (master) and the memory responder (slave).
// The I/O side-band signals exist only when OTTER_MMIO_EN is defined.
interface otter_mem_responder_if;
    // A strobe is taken only while the responder is idle. Each access ends with
    // exactly one single-cycle ready pulse on its own port, and dout/err are valid in that cycle.
    logic        rden1;
    logic [31:0] addr1;
    logic [31:0] dout1;
    logic        ready1;
    logic        rden2;
    logic        we2;
    logic [31:0] addr2;
    logic [1:0]  size2;
    logic        unsigned2;
    logic [31:0] din2;
    logic [31:0] dout2;
    logic        ready2;
    logic        err2;
`ifdef OTTER_MMIO_EN
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
`endif

    modport master (
        output rden1, addr1, rden2, we2, addr2, size2, unsigned2, din2,
        input  dout1, ready1, dout2, ready2, err2
`ifdef OTTER_MMIO_EN
        , input io_rd, io_wr, io_addr, io_wdata
        , output io_rdata
`endif
    );

    modport slave (
        input  rden1, addr1, rden2, we2, addr2, size2, unsigned2, din2,
        output dout1, ready1, dout2, ready2, err2
`ifdef OTTER_MMIO_EN
        , output io_rd, io_wr, io_addr, io_wdata
        , input io_rdata
`endif
    );
endinterface

// File: rtl/otter_mem_responder.sv
// Shared-RAM responder for OTTER fetch (port 1) and load/store (port 2) with wait states.
// Optional memory-mapped I/O bypass on port 2 is enabled by defining OTTER_MMIO_EN.
module otter_mem_responder #(
    parameter int          ADDR_W      = 14,
    parameter int          WAIT_STATES = 1
`ifdef OTTER_MMIO_EN
    , parameter logic [31:0] MMIO_BASE = 32'h1100_0000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    otter_mem_responder_if.slave   bus,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2, ST_IO = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] paddr_q, paddr_d;
    logic        port_q, wr_q, uns_q, io_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, din_q;

    logic        launch, l_port, l_wr, l_uns, l_io;
    logic [1:0]  l_size;
    logic [31:0] l_addr, l_din;

    logic        op_port, op_wr, op_uns, op_io, op_mis, resp_go;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_din;

    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] widx;
    logic [31:0] rdata, load_data, wdata;
    logic [3:0]  wmask;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    logic        ready1_q, ready2_q, err2_q;
    logic [31:0] dout1_q, dout2_q;

    function automatic logic mis_f(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   mis_f = 1'b0;
            2'b01:   mis_f = a[0];
            default: mis_f = |a;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        paddr_d = paddr_q;
        launch  = 1'b0;
        l_port  = 1'b0;
        l_wr    = 1'b0;
        l_uns   = 1'b0;
        l_size  = 2'b10;
        l_addr  = bus.addr1;
        l_din   = bus.din2;
        l_io    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Port 2 wins a tie; a concurrent fetch is parked and replayed after RESP.
                if (bus.rden2 || bus.we2) begin
                    launch = 1'b1;
                    l_port = 1'b1;
                    l_wr   = bus.we2;
                    l_uns  = bus.unsigned2;
                    l_size = bus.size2;
                    l_addr = bus.addr2;
                    if (bus.rden1) begin
                        pend_d  = 1'b1;
                        paddr_d = bus.addr1;
                    end
                end else if (bus.rden1) begin
                    launch = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_IO:   state_d = ST_RESP;
            default: begin
                if (pend_q) begin
                    launch = 1'b1;
                    l_addr = paddr_q;
                    pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
`ifdef OTTER_MMIO_EN
        l_io = l_port && (l_addr >= MMIO_BASE) && !mis_f(l_size, l_addr[1:0]);
`endif
        if (launch) begin
            if (l_io) begin
                state_d = ST_IO;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = ST_RESP;
            end
        end
    end

    // With zero wait states the response is built from the request being launched this cycle.
    assign op_port = launch ? l_port : port_q;
    assign op_wr   = launch ? l_wr   : wr_q;
    assign op_uns  = launch ? l_uns  : uns_q;
    assign op_io   = launch ? l_io   : io_q;
    assign op_size = launch ? l_size : size_q;
    assign op_addr = launch ? l_addr : addr_q;
    assign op_din  = launch ? l_din  : din_q;
    assign op_mis  = op_port && mis_f(op_size, op_addr[1:0]);
    assign resp_go = (state_d == ST_RESP);

    assign widx  = op_addr[ADDR_W+1:2];
    assign rdata = mem[widx];
    assign sel_b = rdata[{op_addr[1:0], 3'b000} +: 8];
    assign sel_h = op_addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        wdata     = op_din;
        wmask     = 4'b1111;
        case (op_size)
            2'b00: begin
                load_data = op_uns ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
                wdata     = {4{op_din[7:0]}};
                wmask     = 4'b0001 << op_addr[1:0];
            end
            2'b01: begin
                load_data = op_uns ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
                wdata     = {2{op_din[15:0]}};
                wmask     = op_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && resp_go && op_port && op_wr && !op_mis && !op_io) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            pend_q   <= 1'b0;
            paddr_q  <= 32'h0;
            port_q   <= 1'b0;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            io_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            din_q    <= 32'h0;
            ready1_q <= 1'b0;
            ready2_q <= 1'b0;
            err2_q   <= 1'b0;
            dout1_q  <= 32'h0;
            dout2_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            paddr_q <= paddr_d;
            if (launch) begin
                port_q <= l_port;
                wr_q   <= l_wr;
                uns_q  <= l_uns;
                io_q   <= l_io;
                size_q <= l_size;
                addr_q <= l_addr;
                din_q  <= l_din;
            end
            ready1_q <= resp_go && !op_port;
            ready2_q <= resp_go && op_port;
            err2_q   <= resp_go && op_port && op_mis;
            if (resp_go && !op_port) dout1_q <= rdata;
            if (resp_go && op_port) begin
                if (op_mis)     dout2_q <= 32'h0;
`ifdef OTTER_MMIO_EN
                else if (op_io) dout2_q <= bus.io_rdata;
`endif
                else            dout2_q <= load_data;
            end
        end
    end

    assign bus.dout1  = dout1_q;
    assign bus.ready1 = ready1_q;
    assign bus.dout2  = dout2_q;
    assign bus.ready2 = ready2_q;
    assign bus.err2   = err2_q;
    assign dbg_state  = state_q;

`ifdef OTTER_MMIO_EN
    assign bus.io_rd    = (state_q == ST_IO) && !wr_q;
    assign bus.io_wr    = (state_q == ST_IO) && wr_q;
    assign bus.io_addr  = addr_q;
    assign bus.io_wdata = din_q;
`else
    // Address bits above the RAM index alias and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^op_addr[31:ADDR_W+2];
`endif
endmodule

// File: tb/tb_otter_mem_responder.sv
// Directed bench for otter_mem_responder with WAIT_STATES=1 and hand-computed expectations.
module tb_otter_mem_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    int         overlap = 0;

    otter_mem_responder_if bus();

    otter_mem_responder #(.ADDR_W(14), .WAIT_STATES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.ready1 && bus.ready2) overlap++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rden1 = 1'b0; bus.addr1 = 32'h0;
        bus.rden2 = 1'b0; bus.we2 = 1'b0; bus.addr2 = 32'h0;
        bus.size2 = 2'b10; bus.unsigned2 = 1'b0; bus.din2 = 32'h0;
`ifdef OTTER_MMIO_EN
        bus.io_rdata = 32'h0;
`endif
    endtask

    // One port-2 access; lat counts negedges after the capture edge until ready2.
    task automatic req2(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                        input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        bus.we2 = w; bus.rden2 = !w; bus.addr2 = a; bus.size2 = sz; bus.unsigned2 = u; bus.din2 = d;
        @(negedge clk);
        bus.we2 = 1'b0; bus.rden2 = 1'b0;
        lat = 1;
        while (!bus.ready2 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.dout2;
        er = bus.err2;
    endtask

    logic [31:0] rd, d1, d2;
    logic        er;
    int          lat, lat1, lat2, r2_seen, cnt;

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready1", {31'h0, bus.ready1}, 32'h0);
        check("rst_ready2", {31'h0, bus.ready2}, 32'h0);
        check("rst_err2", {31'h0, bus.err2}, 32'h0);
        check("rst_dout1", bus.dout1, 32'h0);
        check("rst_dout2", bus.dout2, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        rst = 1'b0;

        req2(1'b1, 32'h4, 2'b10, 1'b0, 32'h0051_0113, rd, er, lat);
        check("sw4_lat", lat, 2);
        check("sw4_err", {31'h0, er}, 32'h0);
        req2(1'b1, 32'h0, 2'b10, 1'b0, 32'hCAFE_0001, rd, er, lat);

        // Instruction fetch of word 1.
        @(negedge clk);
        bus.rden1 = 1'b1; bus.addr1 = 32'h0000_0004;
        @(negedge clk);
        bus.rden1 = 1'b0;
        lat = 1; r2_seen = 0;
        while (!bus.ready1 && lat < 16) begin
            if (bus.ready2) r2_seen++;
            @(negedge clk);
            lat++;
        end
        check("fetch_lat", lat, 2);
        check("fetch_dout1", bus.dout1, 32'h0051_0113);
        check("fetch_no_ready2", r2_seen, 0);

        req2(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
        req2(1'b1, 32'h102, 2'b00, 1'b0, 32'hFFFF_FF5A, rd, er, lat);
        req2(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("lw_100", rd, 32'hDE5A_BEEF);
        check("lw_100_lat", lat, 2);

        req2(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, rd, er, lat);
        check("lb_103", rd, 32'hFFFF_FFDE);
        req2(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, rd, er, lat);
        check("lbu_103", rd, 32'h0000_00DE);
        req2(1'b0, 32'h102, 2'b01, 1'b0, 32'h0, rd, er, lat);
        check("lh_102", rd, 32'hFFFF_DE5A);
        req2(1'b0, 32'h100, 2'b01, 1'b1, 32'h0, rd, er, lat);
        check("lhu_100", rd, 32'h0000_BEEF);
        req2(1'b0, 32'h100, 2'b00, 1'b0, 32'h0, rd, er, lat);
        check("lb_100", rd, 32'hFFFF_FFEF);

        // Misaligned half store: error pulse, no write.
        req2(1'b1, 32'h101, 2'b01, 1'b0, 32'h0000_1111, rd, er, lat);
        check("sh_101_err", {31'h0, er}, 32'h1);
        check("sh_101_dout", rd, 32'h0);
        @(negedge clk);
        check("sh_101_pulse_ready", {31'h0, bus.ready2}, 32'h0);
        check("sh_101_pulse_err", {31'h0, bus.err2}, 32'h0);
        req2(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("lw_after_mis", rd, 32'hDE5A_BEEF);
        check("lw_after_mis_err", {31'h0, er}, 32'h0);

        req2(1'b0, 32'h0001_0100, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("lw_alias", rd, 32'hDE5A_BEEF);
        req2(1'b0, 32'h102, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("lw_mis_err", {31'h0, er}, 32'h1);
        check("lw_mis_dout", rd, 32'h0);
        req2(1'b0, 32'h100, 2'b11, 1'b0, 32'h0, rd, er, lat);
        check("size3_word", rd, 32'hDE5A_BEEF);

        // Fetch and load requested in the same cycle.
        @(negedge clk);
        bus.rden1 = 1'b1; bus.addr1 = 32'h0;
        bus.rden2 = 1'b1; bus.addr2 = 32'h100; bus.size2 = 2'b10;
        @(negedge clk);
        bus.rden1 = 1'b0; bus.rden2 = 1'b0;
        lat1 = 0; lat2 = 0; d1 = 32'h0; d2 = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.ready2 && lat2 == 0) begin lat2 = c; d2 = bus.dout2; end
            if (bus.ready1 && lat1 == 0) begin lat1 = c; d1 = bus.dout1; end
            @(negedge clk);
        end
        check("dual_lat2", lat2, 2);
        check("dual_dout2", d2, 32'hDE5A_BEEF);
        check("dual_lat1", lat1, 4);
        check("dual_dout1", d1, 32'hCAFE_0001);

        // Reset during the wait of a store must drop it.
        req2(1'b1, 32'h200, 2'b10, 1'b0, 32'hA5A5_0200, rd, er, lat);
        @(negedge clk);
        bus.we2 = 1'b1; bus.addr2 = 32'h200; bus.size2 = 2'b10; bus.din2 = 32'h1234_5678;
        @(negedge clk);
        bus.we2 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort_state", {30'h0, dbg_state}, 32'h0);
        cnt = 0;
        repeat (6) begin
            if (bus.ready2) cnt++;
            @(negedge clk);
        end
        check("rst_abort_no_ready", cnt, 0);
        req2(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, rd, er, lat);
        check("rst_abort_mem", rd, 32'hA5A5_0200);

        check("ready_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
